// File: rtl/memory_access_pkg.sv
// Shared encodings for the MEM stage: control codes, access sizes
// and the MEM/WB bundle.
package memory_access_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_rw_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_EQ   = 3'b001,
        BR_NE   = 3'b010,
        BR_LT   = 3'b011,
        BR_JALR = 3'b100,
        BR_GE   = 3'b101,
        BR_JAL  = 3'b110
    } mem_br_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } f3_size_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] instr;
    } mem_wb_t;

    // EX hands over the compare result in A; bit 0 carries the LT flag.
    function automatic logic branch_taken(
        input logic [2:0]  br,
        input logic [31:0] a
    );
        logic t;
        t = 1'b0;
        unique case (br)
            BR_EQ:           t = (a == 32'd0);
            BR_NE:           t = (a != 32'd0);
            BR_LT:           t = a[0];
            BR_GE:           t = ~a[0];
            BR_JAL, BR_JALR: t = 1'b1;
            default:         t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store enables/data,
// load extraction with extension, and alignment check.
module mem_lane_align
    import memory_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_src,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic        is_b;
    logic        is_h;
    logic        uns;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_b = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h = (funct3 == F3_H) || (funct3 == F3_HU);
        uns  = (funct3 == F3_BU) || (funct3 == F3_HU);

        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        be         = 4'b1111;
        wdata      = store_src;
        load_data  = rdata;
        misaligned = 1'b0;

        // Any funct3 outside the byte/half codes behaves as a word.
        unique case (1'b1)
            is_b: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_src[7:0]}};
                load_data = uns ? {24'd0, byte_sel}
                                : {{24{byte_sel[7]}}, byte_sel};
            end
            is_h: begin
                be         = 4'b0011 << addr_lo;
                wdata      = {2{store_src[15:0]}};
                load_data  = uns ? {16'd0, half_sel}
                                 : {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// MEM stage: branch resolution, data-memory access FSM with
// timeout, and the MEM/WB pipeline register.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCBranch_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [31:0] Instraction_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        branch_PC_contral,
    output logic [31:0] branch_PC,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        RegWrite_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [31:0] WData_pype3,
    output logic [31:0] Instraction_pype3
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_e  state;
    logic [7:0]  cnt;
    mem_wb_t     wb_q;
    mem_wb_t     wb_next;

    logic        mem_op;
    logic        is_store;
    logic        timeout_hit;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        misaligned;

    mem_lane_align u_lane (
        .addr_lo   (ALU_co_pype[1:0]),
        .funct3    (Instraction_pype2[14:12]),
        .store_src (read_data2_pype2),
        .rdata     (dmem_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .load_data (load_data),
        .misaligned(misaligned)
    );

    assign is_store    = (MemRW_pype2 == MEM_STORE);
    assign mem_op      = is_store || (MemRW_pype2 == MEM_LOAD);
    assign timeout_hit = (cnt == TO_LAST);

    always_comb begin
        mem_stall = 1'b0;
        unique case (state)
            S_IDLE:   mem_stall = mem_op && !misaligned;
            S_ACCESS: mem_stall = !dmem_ready && !timeout_hit;
        endcase
    end

    assign branch_PC         = PCBranch_pype2;
    assign branch_PC_contral = branch_taken(MemBranch_pype2, ALU_co_pype)
                               && !mem_stall;

    // EX/MEM is frozen during ACCESS, so lane data can come straight off it.
    assign dmem_addr  = {ALU_co_pype[31:2], 2'b00};
    assign dmem_we    = dmem_req && is_store;
    assign dmem_be    = dmem_req ? lane_be : 4'b0000;
    assign dmem_wdata = dmem_we ? lane_wdata : 32'd0;

    always_comb begin
        wb_next           = '0;
        wb_next.reg_write = RegWrite_pype2 && !is_store;
        wb_next.wreg      = WReg_pype2;
        wb_next.instr     = Instraction_pype2;
        unique case (MemtoReg_pype2)
            WB_ALU:  wb_next.wdata = ALU_co_pype;
            WB_MEM:  wb_next.wdata = load_data;
            WB_PC4:  wb_next.wdata = PCp4_pype2;
            default: wb_next.wdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            dmem_req  <= 1'b0;
            mem_fault <= 1'b0;
            wb_q      <= '0;
        end else begin
            mem_fault <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    cnt <= 8'd0;
                    if (mem_op && misaligned) begin
                        mem_fault <= 1'b1;
                        wb_q      <= '0;
                    end else if (mem_op) begin
                        state    <= S_ACCESS;
                        dmem_req <= 1'b1;
                        wb_q     <= '0;
                    end else begin
                        wb_q <= wb_next;
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        state    <= S_IDLE;
                        dmem_req <= 1'b0;
                        cnt      <= 8'd0;
                        wb_q     <= wb_next;
                    end else if (timeout_hit) begin
                        state     <= S_IDLE;
                        dmem_req  <= 1'b0;
                        cnt       <= 8'd0;
                        mem_fault <= 1'b1;
                        wb_q      <= '0;
                    end else begin
                        cnt  <= cnt + 8'd1;
                        wb_q <= '0;
                    end
                end
            endcase
        end
    end

    assign RegWrite_pype3    = wb_q.reg_write;
    assign WReg_pype3        = wb_q.wreg;
    assign WData_pype3       = wb_q.wdata;
    assign Instraction_pype3 = wb_q.instr;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a transaction-level model
// and a per-cycle compare process.
module tb_memory_access;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic [31:0] PCBranch_pype2;
    logic [31:0] PCp4_pype2;
    logic [31:0] ALU_co_pype;
    logic [31:0] read_data2_pype2;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2;
    logic [1:0]  MemRW_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [31:0] Instraction_pype2;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        branch_PC_contral;
    logic [31:0] branch_PC;
    logic        mem_stall;
    logic        mem_fault;
    logic        RegWrite_pype3;
    logic [4:0]  WReg_pype3;
    logic [31:0] WData_pype3;
    logic [31:0] Instraction_pype3;

    memory_access #(.TIMEOUT_CYCLES(T)) dut (
        .clk              (clk),
        .rst              (rst),
        .PCBranch_pype2   (PCBranch_pype2),
        .PCp4_pype2       (PCp4_pype2),
        .ALU_co_pype      (ALU_co_pype),
        .read_data2_pype2 (read_data2_pype2),
        .WReg_pype2       (WReg_pype2),
        .RegWrite_pype2   (RegWrite_pype2),
        .MemtoReg_pype2   (MemtoReg_pype2),
        .MemRW_pype2      (MemRW_pype2),
        .MemBranch_pype2  (MemBranch_pype2),
        .Instraction_pype2(Instraction_pype2),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata),
        .branch_PC_contral(branch_PC_contral),
        .branch_PC        (branch_PC),
        .mem_stall        (mem_stall),
        .mem_fault        (mem_fault),
        .RegWrite_pype3   (RegWrite_pype3),
        .WReg_pype3       (WReg_pype3),
        .WData_pype3      (WData_pype3),
        .Instraction_pype3(Instraction_pype3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  rw;
        logic [1:0]  m2r;
        logic [2:0]  br;
        logic        regw;
        logic        late;
        logic [4:0]  wreg;
        logic [7:0]  w;
        logic [31:0] a;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [31:0] pcb;
        logic [31:0] pc4;
        logic [31:0] instr;
    } txn_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic txn_t mk(
        input logic [1:0]  rw,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] rs2,
        input logic [31:0] rdata,
        input logic [1:0]  m2r,
        input logic [2:0]  br,
        input logic        regw,
        input logic [31:0] pcb,
        input logic [31:0] pc4,
        input logic [7:0]  w
    );
        txn_t t;
        t       = '0;
        t.rw    = rw;
        t.a     = a;
        t.rs2   = rs2;
        t.rdata = rdata;
        t.m2r   = m2r;
        t.br    = br;
        t.regw  = regw;
        t.pcb   = pcb;
        t.pc4   = pc4;
        t.w     = w;
        t.wreg  = a[6:2] | 5'd1;
        t.instr = {17'h0ABC, f3, t.wreg, 7'h03};
        return t;
    endfunction

    // ---- behavioural model ----
    function automatic int sz(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit memop(input txn_t t);
        return (t.rw == 2'd1) || (t.rw == 2'd2);
    endfunction

    function automatic bit okal(input txn_t t);
        return (int'(t.a[1:0]) % sz(t.instr[14:12])) == 0;
    endfunction

    function automatic bit acc(input txn_t t);
        return memop(t) && okal(t);
    endfunction

    function automatic bit timed_out(input txn_t t);
        return acc(t) && (int'(t.w) >= T);
    endfunction

    function automatic int tlen(input txn_t t);
        if (!acc(t)) return 1;
        if (int'(t.w) < T) return int'(t.w) + 2;
        return T + 1;
    endfunction

    function automatic logic [31:0] ld(input txn_t t);
        int s;
        int off;
        logic [31:0] mask;
        logic [31:0] v;
        s    = sz(t.instr[14:12]);
        off  = int'(t.a[1:0]);
        mask = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
        v    = (t.rdata >> (8 * off)) & mask;
        if (t.instr[14:12] < 3'd4 && s < 4 && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input txn_t t);
        int s;
        s = sz(t.instr[14:12]);
        return 4'(((1 << s) - 1) << int'(t.a[1:0]));
    endfunction

    function automatic logic [31:0] exp_wd(input txn_t t);
        case (sz(t.instr[14:12]))
            1:       return (t.rs2 & 32'hFF) * 32'h0101_0101;
            2:       return (t.rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return t.rs2;
        endcase
    endfunction

    function automatic bit taken(input txn_t t);
        case (t.br)
            3'd1:       return t.a == 0;
            3'd2:       return t.a != 0;
            3'd3:       return t.a % 2 == 1;
            3'd5:       return t.a % 2 == 0;
            3'd4, 3'd6: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] res_data(input txn_t t);
        case (t.m2r)
            2'd0:    return t.a;
            2'd1:    return ld(t);
            2'd2:    return t.pc4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit res_rw(input txn_t t);
        if (memop(t) && !okal(t)) return 1'b0;
        if (timed_out(t)) return 1'b0;
        return t.regw && (t.rw != 2'd2);
    endfunction

    function automatic bit res_fault(input txn_t t);
        return (memop(t) && !okal(t)) || timed_out(t);
    endfunction

    // ---- cycle context shared with the compare process ----
    txn_t cur;
    int   cur_k;
    bit   cur_rst;
    bit   ctx_on = 0;

    bit          pend = 0;
    bit          e_rw, e_fault, e_all;
    logic [31:0] e_wd, e_ins;
    logic [4:0]  e_wr;
    bit          c_stall, c_req, c_tk;
    int          c_len;

    always @(negedge clk) begin
        if (ctx_on) begin
            if (pend) begin
                chk("regwrite3", RegWrite_pype3, e_rw);
                chk("mem_fault", mem_fault, e_fault);
                if (e_rw || e_all) begin
                    chk("wdata3", WData_pype3, e_wd);
                    chk("wreg3", WReg_pype3, e_wr);
                    chk("instr3", Instraction_pype3, e_ins);
                end
            end
            c_len   = tlen(cur);
            c_stall = acc(cur) && (cur_k < c_len - 1);
            c_req   = acc(cur) && (cur_k >= 1);
            c_tk    = taken(cur) && !c_stall;
            chk("mem_stall", mem_stall, c_stall);
            chk("dmem_req", dmem_req, c_req);
            chk("br_ctl", branch_PC_contral, c_tk);
            if (c_tk) chk("br_pc", branch_PC, cur.pcb);
            if (c_req) begin
                chk("dmem_we", dmem_we, cur.rw == 2'd2);
                chk("dmem_be", dmem_be, exp_be(cur));
                chk("dmem_addr", dmem_addr, {cur.a[31:2], 2'b00});
                if (cur.rw == 2'd2) chk("dmem_wdata", dmem_wdata, exp_wd(cur));
            end
            e_all = 0;
            if (cur_rst) begin
                e_rw = 0; e_fault = 0; e_wd = 0; e_wr = 0; e_ins = 0;
                e_all = 1;
            end else if (cur_k == c_len - 1) begin
                e_rw    = res_rw(cur);
                e_fault = res_fault(cur);
                e_wd    = res_data(cur);
                e_wr    = cur.wreg;
                e_ins   = cur.instr;
            end else begin
                e_rw = 0; e_fault = 0;
            end
            pend = 1;
        end
    end

    // ---- driver ----
    int          nstall;
    bit          saw_req, we_s, br_s;
    logic [3:0]  be_s;
    logic [31:0] addr_s, wd_s;

    task automatic drive(input txn_t t, input int k, input bit r);
        PCBranch_pype2    = t.pcb;
        PCp4_pype2        = t.pc4;
        ALU_co_pype       = t.a;
        read_data2_pype2  = t.rs2;
        WReg_pype2        = t.wreg;
        RegWrite_pype2    = t.regw;
        MemtoReg_pype2    = t.m2r;
        MemRW_pype2       = t.rw;
        MemBranch_pype2   = t.br;
        Instraction_pype2 = t.instr;
        dmem_rdata        = t.rdata;
        dmem_ready        = acc(t) ? (k == int'(t.w) + 1) : t.late;
        rst               = r;
        cur               = t;
        cur_k             = k;
        cur_rst           = r;
    endtask

    task automatic run(input txn_t t, input int rst_at);
        int n;
        n = (rst_at >= 0) ? rst_at + 1 : tlen(t);
        nstall = 0; saw_req = 0; we_s = 0; br_s = 0;
        be_s = 0; addr_s = 0; wd_s = 0;
        for (int k = 0; k < n; k++) begin
            drive(t, k, k == rst_at);
            #1;
            if (mem_stall) nstall++;
            if (branch_PC_contral) br_s = 1;
            if (dmem_req) begin
                saw_req = 1; we_s = dmem_we; be_s = dmem_be;
                addr_s = dmem_addr; wd_s = dmem_wdata;
            end
            @(posedge clk);
            #1;
        end
        rst = 0;
    endtask

    txn_t nop, t;

    initial begin
        clk = 0;
        nop = mk(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 2'd0, 3'd0, 1'b0,
                 32'd0, 32'd0, 8'd0);
        drive(nop, 0, 1'b1);
        ctx_on = 1;
        @(posedge clk); #1;
        run(nop, 0);

        // lw, zero-wait
        t = mk(2'd1, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);
        chk("t1_nstall", nstall, 1);
        chk("t1_be", be_s, 4'b1111);
        chk("t1_addr", addr_s, 32'h100);
        chk("t1_rw", RegWrite_pype3, 1'b1);
        chk("t1_wdata", WData_pype3, 32'hDEADBEEF);

        // byte / half loads
        t = mk(2'd1, 3'd0, 32'h103, 32'd0, 32'h80FFFF00, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);
        chk("lb_be", be_s, 4'b1000);
        chk("lb_wdata", WData_pype3, 32'hFFFFFF80);
        t = mk(2'd1, 3'd4, 32'h103, 32'd0, 32'h80FFFF00, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd1);
        run(t, -1);
        chk("lbu_wdata", WData_pype3, 32'h00000080);
        t = mk(2'd1, 3'd5, 32'h102, 32'd0, 32'h80FFFF00, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);
        chk("lhu_wdata", WData_pype3, 32'h000080FF);
        t = mk(2'd1, 3'd1, 32'h102, 32'd0, 32'h80FFFF00, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);

        // stores
        t = mk(2'd2, 3'd1, 32'h202, 32'h1234ABCD, 32'd0, 2'd0, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd3);
        run(t, -1);
        chk("sh_nstall", nstall, 4);
        chk("sh_be", be_s, 4'b1100);
        chk("sh_wdata", wd_s, 32'hABCDABCD);
        chk("sh_we", we_s, 1'b1);
        chk("sh_rw", RegWrite_pype3, 1'b0);
        t = mk(2'd2, 3'd0, 32'h201, 32'h1234ABCD, 32'd0, 2'd0, 3'd0, 1'b0,
               32'd0, 32'd0, 8'd1);
        run(t, -1);
        t = mk(2'd2, 3'd2, 32'h204, 32'hCAFEF00D, 32'd0, 2'd0, 3'd0, 1'b0,
               32'd0, 32'd0, 8'd0);
        run(t, -1);

        // misaligned
        t = mk(2'd1, 3'd2, 32'h101, 32'd0, 32'h11223344, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);
        chk("mis_req", saw_req, 1'b0);
        chk("mis_nstall", nstall, 0);
        chk("mis_fault", mem_fault, 1'b1);
        chk("mis_rw", RegWrite_pype3, 1'b0);
        t = mk(2'd1, 3'd1, 32'h103, 32'd0, 32'h11223344, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);

        // branches and jumps
        t = mk(2'd0, 3'd0, 32'd5, 32'd0, 32'd0, 2'd0, 3'd2, 1'b0,
               32'h400, 32'h10, 8'd0);
        run(t, -1);
        chk("bne_tk", br_s, 1'b1);
        chk("bne_pc", branch_PC, 32'h400);
        t = mk(2'd0, 3'd0, 32'd5, 32'd0, 32'd0, 2'd0, 3'd1, 1'b0,
               32'h400, 32'h10, 8'd0);
        run(t, -1);
        chk("beq_tk", br_s, 1'b0);
        t = mk(2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 2'd0, 3'd1, 1'b0,
               32'h440, 32'h14, 8'd0);
        run(t, -1);
        t = mk(2'd0, 3'd0, 32'd1, 32'd0, 32'd0, 2'd0, 3'd3, 1'b0,
               32'h480, 32'h18, 8'd0);
        run(t, -1);
        t = mk(2'd0, 3'd0, 32'd1, 32'd0, 32'd0, 2'd0, 3'd5, 1'b0,
               32'h4C0, 32'h1C, 8'd0);
        run(t, -1);
        t = mk(2'd0, 3'd0, 32'h500, 32'd0, 32'd0, 2'd2, 3'd4, 1'b1,
               32'h500, 32'h84, 8'd0);
        run(t, -1);
        chk("jalr_tk", br_s, 1'b1);
        chk("jalr_wdata", WData_pype3, 32'h84);
        t = mk(2'd3, 3'd0, 32'h1234, 32'd0, 32'd0, 2'd0, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd0);
        run(t, -1);
        chk("alu_wdata", WData_pype3, 32'h1234);

        // timeout, then reset in the middle of an access
        t = mk(2'd1, 3'd2, 32'h300, 32'd0, 32'h55AA55AA, 2'd1, 3'd0, 1'b1,
               32'd0, 32'd0, 8'd10);
        run(t, -1);
        chk("to_nstall", nstall, T);
        chk("to_fault", mem_fault, 1'b1);
        chk("to_rw", RegWrite_pype3, 1'b0);
        run(t, 2);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_rw", RegWrite_pype3, 1'b0);
        chk("rst_wdata", WData_pype3, 32'd0);
        chk("rst_fault", mem_fault, 1'b0);
        nop.late = 1'b1;
        run(nop, -1);
        nop.late = 1'b0;
        run(nop, -1);
        run(nop, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
